// File: rtl/wb_write_queue_pkg.sv
// rtl/wb_write_queue_pkg.sv - shared widths, default depth and queue entry type
package wb_write_queue_pkg;

  localparam int REG_ADDR_W    = 5;
  localparam int DATA_W        = 32;
  localparam int DEFAULT_DEPTH = 4;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } wbq_entry_t;

endpackage

// File: rtl/wbq_match.sv
// rtl/wbq_match.sv - hazard lookup: does any occupied entry target register q
module wbq_match
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic [REG_ADDR_W-1:0] rds [DEPTH],
  input  logic [DEPTH-1:0]      occ,
  input  logic [REG_ADDR_W-1:0] q,
  output logic                  hit
);

  // R0 never has a pending write; otherwise OR together every occupied rd match
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (occ[i] && (rds[i] == q)) hit = 1'b1;
    end
    if (q == '0) hit = 1'b0;
  end

endmodule

// File: rtl/wb_write_queue.sv
// rtl/wb_write_queue.sv - two-port write-back queue draining one entry per cycle into the register file
module wb_write_queue
  import wb_write_queue_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   a_valid,
  output logic                   a_ready,
  input  logic [REG_ADDR_W-1:0]  a_rd,
  input  logic [DATA_W-1:0]      a_data,
  input  logic                   b_valid,
  output logic                   b_ready,
  input  logic [REG_ADDR_W-1:0]  b_rd,
  input  logic [DATA_W-1:0]      b_data,
  output logic                   rf_le,
  output logic [REG_ADDR_W-1:0]  rf_rw,
  output logic [DATA_W-1:0]      rf_pw,
  input  logic [REG_ADDR_W-1:0]  qa,
  input  logic [REG_ADDR_W-1:0]  qb,
  output logic                   pend_a,
  output logic                   pend_b,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wbq_entry_t            mem [DEPTH];
  logic [PW-1:0]         head;
  logic [PW-1:0]         tail;
  logic [PW-1:0]         b_slot;
  logic [CW-1:0]         free;
  logic                  pop;
  logic                  a_push;
  logic                  b_push;
  logic [REG_ADDR_W-1:0] rds [DEPTH];
  logic [DEPTH-1:0]      occ;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // The register file accepts every cycle, so a non-empty queue always retires its head
  assign pop  = ~empty;
  assign free = CW'(DEPTH) - count + CW'(pop);

  // Port A wins the slot; B only takes the last free slot when A is idle
  assign a_ready = (free >= CW'(1));
  assign b_ready = (free >= CW'(2)) || (!a_valid && (free >= CW'(1)));

  // Writes to R0 are acknowledged but discarded
  assign a_push = a_valid && a_ready && (a_rd != '0);
  assign b_push = b_valid && b_ready && (b_rd != '0);
  assign b_slot = tail + PW'(a_push);

  assign rf_le = pop;
  assign rf_rw = pop ? mem[head].rd   : '0;
  assign rf_pw = pop ? mem[head].data : '0;

  // Pointer and occupancy bookkeeping; reset drops any same-cycle push or pop
  always_ff @(posedge clk) begin
    if (reset) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(pop);
      tail  <= tail + PW'(a_push) + PW'(b_push);
      count <= count + CW'(a_push) + CW'(b_push) - CW'(pop);
    end
  end

  // Entry storage, A lands before B; contents are left stale and masked by occupancy
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (a_push) mem[tail]   <= '{rd: a_rd, data: a_data};
      if (b_push) mem[b_slot] <= '{rd: b_rd, data: b_data};
    end
  end

  // Occupied slots are those within count positions of head, modulo DEPTH
  always_comb begin
    logic [PW-1:0] off;
    off = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rds[i] = mem[i].rd;
      off    = PW'(i) - head;
      occ[i] = ({1'b0, off} < count);
    end
  end

  wbq_match #(.DEPTH(DEPTH)) u_match_a (
    .rds (rds),
    .occ (occ),
    .q   (qa),
    .hit (pend_a)
  );

  wbq_match #(.DEPTH(DEPTH)) u_match_b (
    .rds (rds),
    .occ (occ),
    .q   (qb),
    .hit (pend_b)
  );

endmodule

// File: tb/tb_wb_write_queue.sv
// tb/tb_wb_write_queue.sv - scoreboard bench for wb_write_queue
module tb_wb_write_queue;
  import wb_write_queue_pkg::*;

  localparam int DEPTH = 4;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   a_valid, b_valid;
  logic                   a_ready, b_ready;
  logic [REG_ADDR_W-1:0]  a_rd, b_rd, qa, qb, rf_rw;
  logic [DATA_W-1:0]      a_data, b_data, rf_pw;
  logic                   rf_le, pend_a, pend_b, full, empty;
  logic [$clog2(DEPTH):0] count;

  wbq_entry_t  sb [$];
  logic [31:0] rf_obs [32];
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 clk = ~clk;

  wb_write_queue #(.DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset   (reset),
    .a_valid (a_valid),
    .a_ready (a_ready),
    .a_rd    (a_rd),
    .a_data  (a_data),
    .b_valid (b_valid),
    .b_ready (b_ready),
    .b_rd    (b_rd),
    .b_data  (b_data),
    .rf_le   (rf_le),
    .rf_rw   (rf_rw),
    .rf_pw   (rf_pw),
    .qa      (qa),
    .qb      (qb),
    .pend_a  (pend_a),
    .pend_b  (pend_b),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: drive at negedge, compare against the model, then advance the model past the posedge
  task automatic cycle(input logic av, input logic [4:0] ard, input logic [31:0] ad,
                       input logic bv, input logic [4:0] brd, input logic [31:0] bd,
                       input logic rst);
    int   sz, fr;
    logic ea, eb, pa, pb;
    logic [4:0]  erw;
    logic [31:0] epw;
    @(negedge clk);
    reset = rst; a_valid = av; a_rd = ard; a_data = ad;
    b_valid = bv; b_rd = brd; b_data = bd;
    #1;
    sz = sb.size();
    fr = DEPTH - sz + ((sz != 0) ? 1 : 0);
    ea = (fr >= 1);
    eb = (fr >= 2) || ((fr >= 1) && !av);
    pa = 1'b0;
    pb = 1'b0;
    erw = '0;
    epw = '0;
    foreach (sb[i]) begin
      if (qa != 0 && sb[i].rd == qa) pa = 1'b1;
      if (qb != 0 && sb[i].rd == qb) pb = 1'b1;
    end
    if (sz != 0) begin
      erw = sb[0].rd;
      epw = sb[0].data;
    end
    check("count",   64'(count), 64'(sz));
    check("empty",   empty,   sz == 0);
    check("full",    full,    sz == DEPTH);
    check("rf_le",   rf_le,   sz != 0);
    check("rf_rw",   rf_rw,   erw);
    check("rf_pw",   rf_pw,   epw);
    check("pend_a",  pend_a,  pa);
    check("pend_b",  pend_b,  pb);
    check("a_ready", a_ready, ea);
    check("b_ready", b_ready, eb);
    if (rst) begin
      sb.delete();
    end else begin
      if (rf_le) rf_obs[rf_rw] = rf_pw;
      if (sz != 0) void'(sb.pop_front());
      if (av && ea && ard != 0) sb.push_back('{rd: ard, data: ad});
      if (bv && eb && brd != 0) sb.push_back('{rd: brd, data: bd});
    end
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
  endtask

  initial begin
    foreach (rf_obs[i]) rf_obs[i] = '0;
    reset = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
    a_rd = '0; b_rd = '0; a_data = '0; b_data = '0; qa = '0; qb = '0;
    repeat (2) @(posedge clk);
    cycle(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(1);

    // single write into an empty queue
    qa = 5'd5;
    cycle(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0);
    idle(2);
    check("single_write_rf5", rf_obs[5], 32'hDEADBEEF);

    // dual push, A before B
    qa = 5'd3; qb = 5'd4;
    cycle(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 32'h22, 1'b0);
    idle(3);
    check("dual_rf3", rf_obs[3], 32'h11);
    check("dual_rf4", rf_obs[4], 32'h22);

    // R0 drop with qa=0
    qa = 5'd0; qb = 5'd0;
    cycle(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 32'h0, 1'b0);
    idle(1);
    check("r0_stays_zero", rf_obs[0], 32'h0);

    // sustained pressure on both ports
    for (int k = 0; k < 20; k++) begin
      qa = 5'($urandom_range(1, 31));
      qb = 5'($urandom_range(0, 31));
      cycle(1'b1, 5'($urandom_range(1, 31)), $urandom,
            1'b1, 5'($urandom_range(1, 31)), $urandom, 1'b0);
    end
    idle(6);

    // reset with three entries queued
    qa = 5'd20; qb = 5'd21;
    cycle(1'b1, 5'd20, 32'hA0, 1'b1, 5'd21, 32'hA1, 1'b0);
    cycle(1'b1, 5'd22, 32'hA2, 1'b1, 5'd23, 32'hA3, 1'b0);
    qa = 5'd22;
    cycle(1'b1, 5'd24, 32'hA4, 1'b0, 5'd0, 32'h0, 1'b1);
    idle(2);

    // repeated rd 7 spanning a pointer wrap; last value must win
    qa = 5'd7; qb = 5'd12;
    idle(1);
    cycle(1'b1, 5'd7,  32'h1,  1'b1, 5'd12, 32'hC, 1'b0);
    cycle(1'b1, 5'd13, 32'hD,  1'b1, 5'd14, 32'hE, 1'b0);
    cycle(1'b1, 5'd7,  32'h2,  1'b0, 5'd0,  32'h0, 1'b0);
    idle(6);
    check("wrap_rf7_final", rf_obs[7], 32'h2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
